irq_prio_encoder: RTL

Parametrised, registered priority encoder for active-low request lines. It is the clocked successor of the 8-line combinational encoder. Each input is synchronised and latched into a pending register, then gated by a per-line mask. The block presents the highest-index enabled pending line as a binary code with a valid/ack handshake. It sits between asynchronous board-level request sources (switches, peripheral strobes) and the controller FSM that services them one at a time.

---
 rtl/irq_prio_encoder_pkg.sv | 20 ++
 rtl/prio_enc_n.sv | 37 +++
 rtl/irq_prio_encoder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/irq_prio_encoder_pkg.sv
// -----------------------------------------------------------------------------
// irq_prio_encoder_pkg
//
// Shared definitions for the registered interrupt priority encoder family:
// default geometry and the state encoding of the output handshake register.
// The code width is derived from N with $clog2 inside each module. It is not
// stored here, so it can never disagree with N.
// -----------------------------------------------------------------------------
package irq_prio_encoder_pkg;

  localparam int DEFAULT_N           = 8;
  localparam int DEFAULT_SYNC_STAGES = 2;

  // Output register state. valid is this state bit.
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_e;

endpackage : irq_prio_encoder_pkg

// File: rtl/prio_enc_n.sv
// -----------------------------------------------------------------------------
// prio_enc_n
//
// Combinational N-to-W highest-index priority encoder.
//
// Ports:
//   vec      in  N  request vector, bit N-1 has the highest priority
//   idx      out W  index of the highest set bit (0 when none set)
//   any_set  out 1  at least one bit of vec is set
// -----------------------------------------------------------------------------
module prio_enc_n
  import irq_prio_encoder_pkg::*;
#(
  parameter  int N = DEFAULT_N,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any_set
);

  // Ascending scan: a later, higher index overwrites an earlier one, so the
  // final value is the highest set bit.
  always_comb begin
    // NOTE: every output gets a default before the loop. Otherwise an
    // all-zero vec leaves idx unassigned and a latch is inferred.
    idx     = '0;
    any_set = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx     = W'(i);
        any_set = 1'b1;
      end
    end
  end

endmodule : prio_enc_n

// File: rtl/irq_prio_encoder.sv
// -----------------------------------------------------------------------------
// irq_prio_encoder
//
// Registered priority encoder for active-low, asynchronous request lines.
// Each line is synchronised and optionally edge-detected, then latched into a
// pending register. The highest-index pending line that the mask enables is
// presented as a binary code with a valid/ack handshake. Once presented, a code
// is held until ack, even if higher-priority lines become pending.
//
// Parameters:
//   N            number of request lines (2..32), line N-1 highest priority
//   EDGE         0 = level mode, 1 = falling-edge mode
//   SYNC_STAGES  synchroniser depth per line (>= 2)
//
// Ports:
//   clk    in  1  clock, all state on rising edge
//   rst_n  in  1  asynchronous active-low reset
//   req_n  in  N  active-low request lines, asynchronous to clk
//   mask   in  N  1 = line may be presented (selection only)
//   ack    in  1  consumer accepts the presented code; ignored while valid=0
//   code   out W  presented index, 0 while valid=0
//   valid  out 1  code is meaningful and held stable
//   pend   out N  pending register, unmasked, for status/debug
// -----------------------------------------------------------------------------
module irq_prio_encoder
  import irq_prio_encoder_pkg::*;
#(
  parameter  int N           = DEFAULT_N,
  parameter  int EDGE        = 0,
  parameter  int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  localparam int W           = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_n,
  input  logic [N-1:0] mask,
  input  logic         ack,
  output logic [W-1:0] code,
  output logic         valid,
  output logic [N-1:0] pend
);

  // ---------------------------------------------------------------------------
  // Synchroniser and edge detect. Everything resets to 1 (inactive), so a line
  // that is already low when reset is released counts as a fresh fall.
  // ---------------------------------------------------------------------------
  logic [N-1:0] sync_q [SYNC_STAGES];
  logic [N-1:0] s;
  logic [N-1:0] s_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
    end else begin
      // NOTE: non-blocking assignments let each stage sample the previous
      // stage's old value, so this forms a real shift chain, not one wire.
      sync_q[0] <= req_n;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_d <= '1;
    else        s_d <= s;
  end

  // ---------------------------------------------------------------------------
  // Pending register. A set and a clear of the same bit on the same edge leave
  // the bit set, so a request that arrives on the ack edge is not lost.
  // ---------------------------------------------------------------------------
  logic [N-1:0] set_vec;
  logic [N-1:0] clear_vec;
  logic [N-1:0] pend_q;
  logic [W-1:0] code_q;
  state_e       state_q;

  always_comb begin
    set_vec = (EDGE != 0) ? (s_d & ~s) : ~s;
  end

  always_comb begin
    clear_vec = '0;
    if (state_q == ST_PRESENT && ack) clear_vec[code_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= (pend_q & ~clear_vec) | set_vec;
  end

  // ---------------------------------------------------------------------------
  // Selection. The mask gates only what may be presented. Masked lines keep
  // accumulating in pend_q.
  // ---------------------------------------------------------------------------
  logic [N-1:0] cand;
  logic [W-1:0] winner;
  logic         cand_any;

  assign cand = pend_q & mask;

  prio_enc_n #(.N(N)) u_enc (
    .vec     (cand),
    .idx     (winner),
    .any_set (cand_any)
  );

  // ---------------------------------------------------------------------------
  // Output handshake register. The code is loaded only when the block is idle,
  // so it stays stable during PRESENT. After each ack there is a one-cycle
  // idle bubble.
  // ---------------------------------------------------------------------------
  state_e       state_d;
  logic [W-1:0] code_d;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cand_any) begin
          state_d = ST_PRESENT;
          code_d  = winner;
        end
      end
      ST_PRESENT: begin
        if (ack) begin
          state_d = ST_IDLE;
          code_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        code_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
    end
  end

  assign code  = code_q;
  assign valid = (state_q == ST_PRESENT);
  assign pend  = pend_q;

endmodule : irq_prio_encoder
